// File: rtl/keypad_pkg.sv
// Shared types and the keypad ASCII layout for the 4x4 matrix scanner.
// The key index is row*4+col and the layout is "123A/456B/789C/*0#D".
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_REL_DB
  } kp_state_e;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_ONE,
    CLS_MULTI
  } kp_class_e;

  typedef logic [15:0] key_map_t;

  localparam logic [6:0] KEY_ASCII [16] = '{
    7'h31, 7'h32, 7'h33, 7'h41,
    7'h34, 7'h35, 7'h36, 7'h42,
    7'h37, 7'h38, 7'h39, 7'h43,
    7'h2A, 7'h30, 7'h23, 7'h44
  };

  function automatic logic [6:0] key_to_ascii(input logic [3:0] idx);
    return KEY_ASCII[idx];
  endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Row strobe generator: each row is driven low for SCAN_DIV clocks.
// sample_en marks the last clock of a slot, frame_end the last slot of a frame.
module keypad_scan_timer #(
  parameter int ROWS     = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [ROWS-1:0]         row_drive_o,
  output logic [$clog2(ROWS)-1:0] row_o,
  output logic                    sample_en_o,
  output logic                    frame_end_o
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(ROWS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

  logic          active_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    slot_d = slot_q;
    row_d  = row_q;
    if (active_q) begin
      if (slot_q == SLOT_LAST) begin
        slot_d = '0;
        row_d  = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        slot_d = slot_q + SW'(1);
      end
    end
  end

  // active_q keeps all rows released for the reset cycle itself
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      slot_q   <= '0;
      row_q    <= '0;
    end else begin
      active_q <= 1'b1;
      slot_q   <= slot_d;
      row_q    <= row_d;
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign row_drive_o[gi] = !(active_q && (row_q == RW'(gi)));
  end

  assign row_o       = row_q;
  assign sample_en_o = active_q && (slot_q == SLOT_LAST);
  assign frame_end_o = sample_en_o && (row_q == ROW_LAST);

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: synchronizes columns, captures a per-frame key map,
// debounces whole frames and presents one ASCII event per press with a valid/ready handshake.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] row_drive,
  input  logic [COLS-1:0] col_sense,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [3:0]      key_index,
  output logic [6:0]      key_ascii,
  output logic            overrun
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);
  localparam bit DB_SINGLE = (DEBOUNCE_SCANS == 1);

  logic [$clog2(ROWS)-1:0] row;
  logic                    sample_en;
  logic                    frame_end;

  keypad_scan_timer #(
    .ROWS     (ROWS),
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_drive_o (row_drive),
    .row_o       (row),
    .sample_en_o (sample_en),
    .frame_end_o (frame_end)
  );

  logic [COLS-1:0] col_meta_q, col_sync_q;
  key_map_t        map_q, map_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
      map_q      <= '0;
    end else begin
      col_meta_q <= col_sense;
      col_sync_q <= col_meta_q;
      map_q      <= map_d;
    end
  end

  // map_d already includes the row being sampled, so it is complete at frame_end
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_map_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_map_col
      assign map_d[gi*COLS+gj] = (sample_en && (row == gi[$clog2(ROWS)-1:0]))
                                 ? ~col_sync_q[gj] : map_q[gi*COLS+gj];
    end
  end

  logic [4:0] pop;
  logic [3:0] hit_idx;
  kp_class_e  cls;

  always_comb begin
    pop     = '0;
    hit_idx = '0;
    for (int k = 0; k < 16; k++) begin
      if (map_d[k]) begin
        pop     = pop + 5'd1;
        hit_idx = 4'(k);
      end
    end
    if (pop == 5'd0)      cls = CLS_NONE;
    else if (pop == 5'd1) cls = CLS_ONE;
    else                  cls = CLS_MULTI;
  end

  kp_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic          accept_q, accept_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept_d = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        ST_IDLE: begin
          if (cls == CLS_ONE) begin
            cand_d = hit_idx;
            cnt_d  = CNT_ONE;
            if (DB_SINGLE) begin
              state_d  = ST_HELD;
              accept_d = 1'b1;
            end else begin
              state_d = ST_PRESS_DB;
            end
          end
        end
        ST_PRESS_DB: begin
          if (cls == CLS_ONE && hit_idx == cand_q) begin
            if (cnt_q + CNT_ONE >= CNT_MAX) begin
              cnt_d    = CNT_MAX;
              state_d  = ST_HELD;
              accept_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (cls == CLS_NONE) begin
            cnt_d   = CNT_ONE;
            state_d = DB_SINGLE ? ST_IDLE : ST_REL_DB;
          end
        end
        ST_REL_DB: begin
          if (cls == CLS_NONE) begin
            if (cnt_q + CNT_ONE >= CNT_MAX) begin
              cnt_d   = CNT_MAX;
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  logic       key_valid_q;
  logic [3:0] key_index_q;
  logic [6:0] key_ascii_q;
  logic       overrun_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      accept_q    <= 1'b0;
      key_valid_q <= 1'b0;
      key_index_q <= '0;
      key_ascii_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      accept_q  <= accept_d;
      overrun_q <= 1'b0;
      // a handshake in the same clock frees the slot for the new event
      if (accept_q) begin
        if (!key_valid_q || key_ready) begin
          key_valid_q <= 1'b1;
          key_index_q <= cand_q;
          key_ascii_q <= key_to_ascii(cand_q);
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (key_valid_q && key_ready) begin
        key_valid_q <= 1'b0;
      end
    end
  end

  assign key_valid = key_valid_q;
  assign key_index = key_index_q;
  assign key_ascii = key_ascii_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-clock frames).
// An emulated keypad drives the columns; a frame-level model predicts all outputs every cycle.
module tb_keypad_matrix_scanner;

  localparam int FRAME = 16;
  localparam int DB    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_drive;
  logic [3:0] col_sense;
  logic       key_valid;
  logic       key_ready = 1'b1;
  logic [3:0] key_index;
  logic [6:0] key_ascii;
  logic       overrun;

  logic [15:0] mask = '0;

  int n_vec = 0;
  int n_bad = 0;

  keypad_matrix_scanner #(
    .ROWS           (4),
    .COLS           (4),
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_drive (row_drive),
    .col_sense (col_sense),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_index (key_index),
    .key_ascii (key_ascii),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_sense = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_drive[r] && mask[r*4+c]) col_sense[c] = 1'b0;
  end

  function automatic logic [6:0] ascii_of(input int idx);
    string lay;
    byte   b;
    lay = "123A456B789C*0#D";
    b   = lay[idx];
    return b[6:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Frame-level model: edges counted from reset release, frame k ends on edge 17+16k
  int         edge_n = 0;
  int         mode = 0;   // 0 idle, 1 confirming press, 2 held, 3 confirming release
  int         run = 0;
  int         cand = 0;
  bit         acc_pend = 0;
  int         acc_idx = 0;
  bit         exp_valid = 0;
  logic [3:0] exp_idx = '0;
  logic [6:0] exp_ascii = '0;
  bit         exp_ov = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      edge_n = 0; mode = 0; run = 0; acc_pend = 0;
      exp_valid = 0; exp_idx = '0; exp_ascii = '0; exp_ov = 0;
    end else begin
      bit hs;
      edge_n++;
      exp_ov = 0;
      hs = exp_valid && key_ready;
      if (acc_pend) begin
        if (!exp_valid || hs) begin
          exp_valid = 1; exp_idx = 4'(acc_idx); exp_ascii = ascii_of(acc_idx);
        end else begin
          exp_ov = 1;
        end
      end else if (hs) begin
        exp_valid = 0;
      end
      acc_pend = 0;
      if (edge_n >= FRAME + 1 && (edge_n - 1) % FRAME == 0) begin
        int  n;
        int  k;
        bit  one;
        n = $countones(mask);
        one = (n == 1);
        k = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) k = i;
        case (mode)
          0: if (one) begin cand = k; run = 1; mode = 1; end
          1: if (one && k == cand) run++; else mode = 0;
          2: if (n == 0) begin run = 1; mode = 3; end
          default: if (n == 0) run++; else mode = 2;
        endcase
        if (mode == 1 && run >= DB) begin acc_pend = 1; acc_idx = cand; mode = 2; end
        if (mode == 3 && run >= DB) mode = 0;
      end
    end
  end

  // DUT event observers feeding the literal checks
  int ev_count = 0;
  int ov_count = 0;
  int rise_edge = 0;

  always @(posedge clk) begin
    if (rst_n && key_valid && key_ready) ev_count++;
    if (rst_n && overrun) ov_count++;
  end

  always @(negedge clk) begin
    logic [3:0] exp_row;
    exp_row = (edge_n == 0) ? 4'hF : ~(4'b0001 << (((edge_n - 1) / 4) % 4));
    check("row_drive", 32'(row_drive), 32'(exp_row));
    check("key_valid", 32'(key_valid), 32'(exp_valid));
    check("key_index", 32'(key_index), 32'(exp_idx));
    check("key_ascii", 32'(key_ascii), 32'(exp_ascii));
    check("overrun",   32'(overrun),   32'(exp_ov));
    if (key_valid && rise_edge == 0) rise_edge = edge_n;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_row", 32'(row_drive), 32'hF);
    check("rst_valid", 32'(key_valid), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_row", 32'(row_drive), 32'hE);
    ev_count = 0; ov_count = 0; rise_edge = 0;
  endtask

  task automatic run_frames(input logic [15:0] m, input int n);
    mask = m;
    repeat (FRAME * n) @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: idle scan, then reset in the middle of a frame
    key_ready = 1'b1;
    do_reset();
    run_frames(16'h0000, 2);
    repeat (8) @(posedge clk);
    #1;
    check("t1_events", 32'(ev_count), 32'd0);
    do_reset();
    run_frames(16'h0000, 1);

    // 2: key 6 held five frames
    do_reset();
    run_frames(16'h0040, 5);
    run_frames(16'h0000, 4);
    check("t2_events", 32'(ev_count), 32'd1);
    check("t2_rise", 32'(rise_edge), 32'd50);
    check("t2_index", 32'(key_index), 32'd6);
    check("t2_ascii", 32'(key_ascii), 32'h36);

    // 3: bounce on key 15
    do_reset();
    run_frames(16'h8000, 2);
    run_frames(16'h0000, 1);
    run_frames(16'h8000, 3);
    run_frames(16'h0000, 4);
    check("t3_events", 32'(ev_count), 32'd1);
    check("t3_rise", 32'(rise_edge), 32'd98);
    check("t3_ascii", 32'(key_ascii), 32'h44);

    // 4: two keys (ghosting) then one released
    do_reset();
    run_frames(16'h0021, 6);
    check("t4_ghost", 32'(ev_count), 32'd0);
    run_frames(16'h0001, 4);
    run_frames(16'h0000, 4);
    check("t4_events", 32'(ev_count), 32'd1);
    check("t4_rise", 32'(rise_edge), 32'd146);
    check("t4_ascii", 32'(key_ascii), 32'h31);

    // 5: backpressure and overrun
    key_ready = 1'b0;
    do_reset();
    run_frames(16'h0100, 4);
    run_frames(16'h0000, 4);
    run_frames(16'h1000, 4);
    run_frames(16'h0000, 4);
    check("t5_ascii", 32'(key_ascii), 32'h37);
    check("t5_overrun", 32'(ov_count), 32'd1);
    check("t5_pending", 32'(key_valid), 32'd1);
    key_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5_drop", 32'(key_valid), 32'd0);
    check("t5_events", 32'(ev_count), 32'd1);

    // 6: held key, short release, long release then re-press
    do_reset();
    run_frames(16'h2000, 20);
    run_frames(16'h0000, 2);
    run_frames(16'h2000, 4);
    check("t6_single", 32'(ev_count), 32'd1);
    run_frames(16'h0000, 4);
    run_frames(16'h2000, 4);
    run_frames(16'h0000, 4);
    check("t6_events", 32'(ev_count), 32'd2);
    check("t6_ascii", 32'(key_ascii), 32'h30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
